// File: rtl/wallclock_ctrl.sv
// Wall-clock time-keeping/time-setting controller: BCD hh:mm:ss chain, set-mode FSM, display blink mask.
// Optional blink phase generation is enabled by defining WALLCLOCK_BLINK_EN.
module wallclock_ctrl #(
    parameter logic [7:0] HOUR_MAX = 8'h23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [1:0] mode,
    output logic [2:0] blink,
    output logic       day_carry
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       mode_q;
    logic       inc_q;
    logic       mode_ev;
    logic       inc_ev;
    logic [7:0] hour_next;
    logic [7:0] minute_next;
    logic [7:0] second_next;
    logic       carry_next;

    // Wrap to zero at max_val; otherwise a BCD increment that never lets the low nibble pass 9.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
        if (val == max_val)
            return 8'h00;
        else if (val[3:0] == 4'h9)
            return {val[7:4] + 4'h1, 4'h0};
        else
            return {val[7:4], val[3:0] + 4'h1};
    endfunction

    assign mode_ev = btn_mode & ~mode_q;
    assign inc_ev  = btn_inc & ~inc_q;
    assign mode    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            mode_q    <= 1'b0;
            inc_q     <= 1'b0;
            hour      <= 8'h00;
            minute    <= 8'h00;
            second    <= 8'h00;
            day_carry <= 1'b0;
        end else begin
            state     <= state_next;
            mode_q    <= btn_mode;
            inc_q     <= btn_inc;
            hour      <= hour_next;
            minute    <= minute_next;
            second    <= second_next;
            day_carry <= carry_next;
        end
    end

    // Time update and state advance are independent, so simultaneous events both take effect.
    always_comb begin
        state_next  = state;
        hour_next   = hour;
        minute_next = minute;
        second_next = second;
        carry_next  = 1'b0;
        case (state)
            RUN: begin
                if (tick_1hz) begin
                    second_next = bcd_inc(second, 8'h59);
                    if (second == 8'h59) begin
                        minute_next = bcd_inc(minute, 8'h59);
                        if (minute == 8'h59) begin
                            hour_next = bcd_inc(hour, HOUR_MAX);
                            if (hour == HOUR_MAX)
                                carry_next = 1'b1;
                        end
                    end
                end
                if (mode_ev)
                    state_next = SET_HOUR;
            end
            SET_HOUR: begin
                if (inc_ev)
                    hour_next = bcd_inc(hour, HOUR_MAX);
                if (mode_ev)
                    state_next = SET_MIN;
            end
            SET_MIN: begin
                if (inc_ev)
                    minute_next = bcd_inc(minute, 8'h59);
                if (mode_ev)
                    state_next = SET_SEC;
            end
            SET_SEC: begin
                if (inc_ev)
                    second_next = bcd_inc(second, 8'h59);
                if (mode_ev)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

`ifdef WALLCLOCK_BLINK_EN
    logic phase;
    logic phase_next;

    // Phase only runs while setting; leaving for RUN clears it so each set session starts visible.
    always_comb begin
        phase_next = phase;
        if (state_next == RUN)
            phase_next = 1'b0;
        else if (tick_1hz && (state != RUN))
            phase_next = ~phase;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            phase <= 1'b0;
        else
            phase <= phase_next;
    end

    always_comb begin
        blink = 3'b000;
        case (state)
            SET_HOUR: blink[2] = phase;
            SET_MIN:  blink[1] = phase;
            SET_SEC:  blink[0] = phase;
            default:  blink    = 3'b000;
        endcase
    end
`else
    assign blink = 3'b000;
`endif

endmodule

// File: tb/tb_wallclock_ctrl.sv
// Directed self-checking bench for wallclock_ctrl; blink expectations follow WALLCLOCK_BLINK_EN.
module tb_wallclock_ctrl;

    logic       clk;
    logic       reset;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic [1:0] mode;
    logic [2:0] blink;
    logic       day_carry;

    int compareCount  = 0;
    int mismatchCount = 0;

    wallclock_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .mode      (mode),
        .blink     (blink),
        .day_carry (day_carry)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive inputs for one clock, then release them; outputs are settled at the returning negedge.
    task automatic applyStimulus(input logic t, input logic m, input logic i);
        @(negedge clk);
        tick_1hz = t;
        btn_mode = m;
        btn_inc  = i;
        @(negedge clk);
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic pressInc(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkTime(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        checkOutput({tag, "_hour"}, hour, h);
        checkOutput({tag, "_min"}, minute, m);
        checkOutput({tag, "_sec"}, second, s);
    endtask

    function automatic logic [2:0] expBlink(input logic [2:0] b);
`ifdef WALLCLOCK_BLINK_EN
        return b;
`else
        return 3'b000 & b;
`endif
    endfunction

    initial begin
        reset    = 1'b1;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        #100;
        reset = 1'b0;
        @(negedge clk);
        checkTime("reset", 8'h00, 8'h00, 8'h00);
        checkOutput("reset_mode", {6'd0, mode}, 8'd0);
        checkOutput("reset_blink", {5'd0, blink}, 8'd0);
        checkOutput("reset_carry", {7'd0, day_carry}, 8'd0);

        // Preload 23:59:58 through the set modes
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("enter_set_hour", {6'd0, mode}, 8'd1);
        pressInc(23);
        checkTime("hour23", 8'h23, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkTime("hour_wrap", 8'h00, 8'h00, 8'h00);
        pressInc(23);
        checkOutput("blink_set_hour_idle", {5'd0, blink}, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("enter_set_min", {6'd0, mode}, 8'd2);
        pressInc(59);
        checkTime("min59", 8'h23, 8'h59, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkTime("min_wrap", 8'h23, 8'h00, 8'h00);
        pressInc(59);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("enter_set_sec", {6'd0, mode}, 8'd3);
        pressInc(58);
        checkTime("preload", 8'h23, 8'h59, 8'h58);

        // Ticks in SET_SEC freeze time and toggle blink
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("set_tick1_blink", {5'd0, blink}, {5'd0, expBlink(3'b001)});
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("set_tick2_blink", {5'd0, blink}, {5'd0, expBlink(3'b000)});
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("set_tick3_blink", {5'd0, blink}, {5'd0, expBlink(3'b001)});
        checkOutput("set_tick_sec", second, 8'h58);

        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("back_run_mode", {6'd0, mode}, 8'd0);
        checkOutput("back_run_blink", {5'd0, blink}, 8'd0);

        // Day rollover
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkTime("t235959", 8'h23, 8'h59, 8'h59);
        checkOutput("carry_early", {7'd0, day_carry}, 8'd0);
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        checkTime("rollover", 8'h00, 8'h00, 8'h00);
        checkOutput("carry_pulse", {7'd0, day_carry}, 8'd1);
        @(negedge clk);
        checkOutput("carry_clear", {7'd0, day_carry}, 8'd0);

        // RUN ignores inc even with a tick
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkTime("tick_inc", 8'h00, 8'h00, 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkTime("run_inc", 8'h00, 8'h00, 8'h01);

        // 12:34:59 -> 12:35:00
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressInc(12);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressInc(34);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressInc(58);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTime("t123459", 8'h12, 8'h34, 8'h59);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkTime("t123500", 8'h12, 8'h35, 8'h00);

        // 12:59:59 -> 13:00:00
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressInc(24);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressInc(59);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTime("t125959", 8'h12, 8'h59, 8'h59);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkTime("t130000", 8'h13, 8'h00, 8'h00);

        // Inc and mode together in SET_HOUR
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("incmode_hour", hour, 8'h14);
        checkOutput("incmode_mode", {6'd0, mode}, 8'd2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Tick and mode together in RUN at 00:00:05
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, 1'b0, 1'b0);
        checkTime("t000005", 8'h00, 8'h00, 8'h05);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("tickmode_sec", second, 8'h06);
        checkOutput("tickmode_mode", {6'd0, mode}, 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressInc(3);
        checkOutput("mid_set_min", minute, 8'h03);

        // Reset takes effect without a clock edge
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkTime("async_reset", 8'h00, 8'h00, 8'h00);
        checkOutput("async_reset_mode", {6'd0, mode}, 8'd0);

        // Button held across reset release gives exactly one event
        btn_mode = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++)
            @(negedge clk);
        checkOutput("held_mode", {6'd0, mode}, 8'd1);
        btn_mode = 1'b0;
        @(negedge clk);
        checkOutput("held_release", {6'd0, mode}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
